// File: rtl/srlatch_driver_if.sv
// Write-port bundle between a requester and the NAND SR-latch driver, including latch S_n/R_n drive and Q readback.
interface srlatch_driver_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             ready;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rdata;
    logic             done;
    logic             err;

    modport master (
        output req, wdata, q,
        input  ready, s_n, r_n, rdata, done, err
    );

    modport slave (
        input  req, wdata, q,
        output ready, s_n, r_n, rdata, done, err
    );
endinterface

// File: rtl/srlatch_driver.sv
// Pulses active-low S_n/R_n into NAND SR latches, releases, reads Q back and retries on mismatch.
// Latency: DONE in cycle k+P+S+1 after accept edge k, plus P+S+1 per retry; READY low while busy.
module srlatch_driver #(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRIES   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    srlatch_driver_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PULSE, RELEASE, CHECK} state_t;

    localparam logic [3:0] P_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] S_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] R_MAX  = 3'(MAX_RETRIES);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [2:0]       retry, retry_nxt;
    logic [WIDTH-1:0] wreg, wreg_nxt;
    logic [WIDTH-1:0] s_n_nxt, r_n_nxt, rdata_nxt;
    logic             done_nxt, err_nxt;

    assign bus.ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // S_n/R_n are computed from the next state so each bit moves between
    // (0,1)/(1,0) and (1,1) in one registered step and never passes (0,0).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        wreg_nxt  = wreg;
        s_n_nxt   = '1;
        r_n_nxt   = '1;
        rdata_nxt = bus.rdata;
        done_nxt  = 1'b0;
        err_nxt   = bus.err;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    wreg_nxt  = bus.wdata;
                    retry_nxt = '0;
                    err_nxt   = 1'b0;
                    cnt_nxt   = P_LOAD;
                    state_nxt = PULSE;
                    s_n_nxt   = ~bus.wdata;
                    r_n_nxt   = bus.wdata;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    cnt_nxt   = S_LOAD;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    s_n_nxt = ~wreg;
                    r_n_nxt = wreg;
                end
            end
            RELEASE: begin
                if (cnt == '0) state_nxt = CHECK;
                else           cnt_nxt   = cnt - 4'd1;
            end
            CHECK: begin
                rdata_nxt = bus.q;
                if (bus.q == wreg) begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (retry < R_MAX) begin
                    retry_nxt = retry + 3'd1;
                    cnt_nxt   = P_LOAD;
                    state_nxt = PULSE;
                    s_n_nxt   = ~wreg;
                    r_n_nxt   = wreg;
                end else begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            retry     <= '0;
            wreg      <= '0;
            bus.s_n   <= '1;
            bus.r_n   <= '1;
            bus.rdata <= '0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            retry     <= retry_nxt;
            wreg      <= wreg_nxt;
            bus.s_n   <= s_n_nxt;
            bus.r_n   <= r_n_nxt;
            bus.rdata <= rdata_nxt;
            bus.done  <= done_nxt;
            bus.err   <= err_nxt;
        end
    end
endmodule

// File: tb/tb_srlatch_driver.sv
// Bench for srlatch_driver: NAND SR latch models on S_n/R_n feed Q back; a scoreboard predicts DONE timing, ERR and RDATA.
`timescale 1ns/1ps
module tb_srlatch_driver;
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] lq0    = '0;
    logic [7:0] lq1    = '0;
    logic [7:0] stuck0 = '0;

    exp_t sb0[$];
    exp_t sb1[$];

    srlatch_driver_if #(.WIDTH(8)) if0 ();
    srlatch_driver_if #(.WIDTH(8)) if1 ();

    srlatch_driver #(.WIDTH(8), .PULSE_CYCLES(2), .SETTLE_CYCLES(1), .MAX_RETRIES(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );
    srlatch_driver #(.WIDTH(8), .PULSE_CYCLES(1), .SETTLE_CYCLES(1), .MAX_RETRIES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // NAND SR latch: S_n low sets, R_n low clears, both high holds.
    always @(if0.s_n or if0.r_n)
        for (int i = 0; i < 8; i++)
            if (!if0.s_n[i])      lq0[i] = 1'b1;
            else if (!if0.r_n[i]) lq0[i] = 1'b0;
    always @(if1.s_n or if1.r_n)
        for (int i = 0; i < 8; i++)
            if (!if1.s_n[i])      lq1[i] = 1'b1;
            else if (!if1.r_n[i]) lq1[i] = 1'b0;

    assign if0.q = lq0 & ~stuck0;
    assign if1.q = lq1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Main-instance scoreboard: P=2, S=1, MAX_RETRIES=1, optional stuck-at-0 bits.
    always @(negedge clk) begin
        chk("safety0", {24'd0, if0.s_n | if0.r_n}, 32'hFF);
        if (rst_n) begin
            if (sb0.size() > 0 && cyc > sb0[0].due) begin
                chk("done_timeout0", cyc, sb0[0].due);
                void'(sb0.pop_front());
            end
            if (if0.done) begin
                if (sb0.size() == 0) chk("spurious_done0", {31'd0, if0.done}, 0);
                else begin
                    exp_t e;
                    e = sb0.pop_front();
                    chk("done_cycle0", cyc, e.due);
                    chk("err0", {31'd0, if0.err}, {31'd0, e.err});
                    chk("rdata0", {24'd0, if0.rdata}, {24'd0, e.rdata});
                end
            end
            if (if0.req && if0.ready) begin
                exp_t e;
                logic [7:0] got;
                got = if0.wdata & ~stuck0;
                e.err   = (got != if0.wdata);
                e.rdata = got;
                e.due   = cyc + 1 + (e.err ? 2 : 1) * 4;
                sb0.push_back(e);
            end
        end
    end

    // Fast-instance scoreboard: P=1, S=1, no faults, so every store succeeds in 3 cycles.
    always @(negedge clk) begin
        chk("safety1", {24'd0, if1.s_n | if1.r_n}, 32'hFF);
        if (rst_n) begin
            if (sb1.size() > 0 && cyc > sb1[0].due) begin
                chk("done_timeout1", cyc, sb1[0].due);
                void'(sb1.pop_front());
            end
            if (if1.done) begin
                if (sb1.size() == 0) chk("spurious_done1", {31'd0, if1.done}, 0);
                else begin
                    exp_t e;
                    e = sb1.pop_front();
                    chk("done_cycle1", cyc, e.due);
                    chk("err1", {31'd0, if1.err}, {31'd0, e.err});
                    chk("rdata1", {24'd0, if1.rdata}, {24'd0, e.rdata});
                end
            end
            if (if1.req && if1.ready) begin
                exp_t e;
                e.err   = 1'b0;
                e.rdata = if1.wdata;
                e.due   = cyc + 1 + 3;
                sb1.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic write0(input logic [7:0] d, input bit keep);
        int n = 0;
        bit seen = 0;
        if0.req   = 1'b1;
        if0.wdata = d;
        while (n < 50 && !seen) begin
            @(negedge clk);
            n++;
            seen = if0.ready;
        end
        chk("accept_timeout", {31'd0, seen}, 1);
        @(posedge clk);
        #1;
        if (!keep) if0.req = 1'b0;
    endtask

    task automatic wait_done0(output int at);
        int n = 0;
        at = -1;
        while (n < 40 && at < 0) begin
            @(negedge clk);
            n++;
            if (if0.done) at = cyc;
        end
        if (at < 0) chk("wait_done", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d1, d2;
        if0.req = 1'b0; if0.wdata = '0;
        if1.req = 1'b0; if1.wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_s_n",   {24'd0, if0.s_n}, 32'hFF);
        chk("rst_r_n",   {24'd0, if0.r_n}, 32'hFF);
        chk("rst_ready", {31'd0, if0.ready}, 1);
        chk("rst_done",  {31'd0, if0.done}, 0);
        chk("rst_err",   {31'd0, if0.err}, 0);
        chk("rst_rdata", {24'd0, if0.rdata}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic store with the pulse pattern observed directly.
        write0(8'hA5, 0);
        @(negedge clk);
        chk("pulse1_s_n", {24'd0, if0.s_n}, 32'h5A);
        chk("pulse1_r_n", {24'd0, if0.r_n}, 32'hA5);
        chk("busy_ready", {31'd0, if0.ready}, 0);
        @(negedge clk);
        chk("pulse2_s_n", {24'd0, if0.s_n}, 32'h5A);
        chk("pulse2_r_n", {24'd0, if0.r_n}, 32'hA5);
        @(negedge clk);
        chk("release_s_n", {24'd0, if0.s_n}, 32'hFF);
        chk("release_r_n", {24'd0, if0.r_n}, 32'hFF);
        wait_done0(d1);
        chk("q_a5", {24'd0, if0.q}, 32'hA5);

        // Overwrite with REQ held through DONE: second accept at the DONE edge.
        write0(8'hFF, 1);
        if0.wdata = 8'h00;
        wait_done0(d1);
        if0.req = 1'b0;
        wait_done0(d2);
        chk("b2b_gap", d2 - d1, 5);
        chk("q_00", {24'd0, if0.q}, 32'h00);
        chk("rdata_00", {24'd0, if0.rdata}, 32'h00);

        // Bit 3 stuck at 0: one retry, then ERR; next accept clears ERR.
        stuck0 = 8'h08;
        write0(8'h08, 0);
        wait_done0(d1);
        @(negedge clk);
        chk("err_hold", {31'd0, if0.err}, 1);
        chk("rdata_hold", {24'd0, if0.rdata}, 32'h00);
        @(posedge clk); #1;
        write0(8'h01, 0);
        @(negedge clk);
        chk("err_clear", {31'd0, if0.err}, 0);
        wait_done0(d1);
        stuck0 = 8'h00;

        // Reset mid-PULSE aborts without DONE.
        write0(8'h55, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #0.001;
        chk("abort_s_n", {24'd0, if0.s_n}, 32'hFF);
        chk("abort_r_n", {24'd0, if0.r_n}, 32'hFF);
        chk("abort_ready", {31'd0, if0.ready}, 1);
        sb0.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, if0.done}, 0);
        end

        // Fast instance: random data, REQ toggled every cycle.
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            if1.req   = ~if1.req;
            if1.wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        if1.req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("sb0_drain", sb0.size(), 0);
        chk("sb1_drain", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d limit=10000", cyc);
        $fatal(1);
    end
endmodule
